// File: rtl/ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_master
// Brief    : Initiator for the shared-bus RAM protocol. Sequences one load or
//            store per request as address strobe, then a write or read strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_master #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  write_address,
    output logic                  write,
    output logic                  read,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [31:0]           data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_XFER = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] c_BUS_BYTE = 2'b00;
    localparam logic [1:0] c_BUS_HALF = 2'b01;
    localparam logic [1:0] c_BUS_WORD = 2'b11;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_write;
    logic                    r_unsigned;
    logic [1:0]              r_size;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    w_accept;
    logic [1:0]              w_bus_size;
    logic [31:0]             w_wdata_masked;
    logic [31:0]             w_load_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_bus_size     = c_BUS_WORD;
        w_wdata_masked = req_wdata;
        case (req_size)
            2'b00: begin
                w_bus_size     = c_BUS_BYTE;
                w_wdata_masked = {24'd0, req_wdata[7:0]};
            end
            2'b01: begin
                w_bus_size     = c_BUS_HALF;
                w_wdata_masked = {16'd0, req_wdata[15:0]};
            end
            default: begin
                w_bus_size     = c_BUS_WORD;
                w_wdata_masked = req_wdata;
            end
        endcase
    end

    // Load data is captured and extended on the edge that ends XFER.
    always_comb begin
        w_load_ext = data;
        case (r_size)
            c_BUS_BYTE: w_load_ext = {{24{data[7] & ~r_unsigned}}, data[7:0]};
            c_BUS_HALF: w_load_ext = {{16{data[15] & ~r_unsigned}}, data[15:0]};
            default:    w_load_ext = data;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_ADDR : S_IDLE;
            S_ADDR:  w_next = S_XFER;
            S_XFER:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= c_BUS_BYTE;
            r_address  <= '0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= w_bus_size;
                r_address  <= req_address;
                r_wdata    <= w_wdata_masked;
            end
            if ((r_state == S_XFER) && !r_write) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign write_address = (r_state == S_ADDR);
    assign write         = (r_state == S_XFER) && r_write;
    assign read          = (r_state == S_XFER) && !r_write;
    assign resp_valid    = (r_state == S_RESP);
    // Stores report zero while the last load result stays held underneath.
    assign resp_rdata    = ((r_state == S_RESP) && r_write) ? 32'd0 : r_rdata;
    assign data_size     = r_size;
    assign address       = r_address;
    assign data          = write ? r_wdata : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bus_master
// Brief    : Self-checking bench with a RAM responder and a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bus_master;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_address;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          write_address;
    logic          write;
    logic          read;
    logic [1:0]    data_size;
    logic [AW-1:0] address;
    wire  [31:0]   data;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    ram_bus_master #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .write_address(write_address), .write(write), .read(read),
        .data_size(data_size), .address(address), .data(data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM responder (byte array, little endian) ----------------
    bit [7:0] mem [0:65535];

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mem[(int'(a) + i) & 16'hFFFF];
        return r;
    endfunction

    logic [31:0] ram_q;
    always_comb ram_q = rd_word(address);
    assign data = read ? ram_q : 32'bz;

    always @(posedge clock) begin
        if (write) begin
            for (int i = 0; i < 4; i++) begin
                if (i < ((data_size == 2'b00) ? 1 : (data_size == 2'b01) ? 2 : 4))
                    mem[(int'(address) + i) & 16'hFFFF] <= data[8*i +: 8];
            end
        end
    end

    // ---------------- Behavioural model ----------------
    function automatic logic [1:0] bus_code(input logic [1:0] sz);
        return (sz == 2'b00) ? 2'b00 : (sz == 2'b01) ? 2'b01 : 2'b11;
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        return (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] sz, input logic u, input logic [31:0] raw);
        logic [31:0] v;
        v = raw & size_mask(sz);
        if (!u && sz == 2'b00 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
        if (!u && sz == 2'b01 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // k = cycles since acceptance: 0 address phase, 1 transfer, 2 response.
    int          cyc = 0;
    int          acc = -100;
    logic        m_w = 1'b0;
    logic        m_u = 1'b0;
    logic [1:0]  m_sz = 2'b00;
    logic [15:0] m_a = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] hold = '0;
    logic [15:0] e_addr = '0;
    logic [1:0]  e_ds = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            acc    <= -100;
            hold   <= 32'd0;
            e_addr <= '0;
            e_ds   <= 2'b00;
        end else begin
            if ((cyc - acc) == 1 && !m_w) hold <= extend(m_sz, m_u, rd_word(m_a));
            if ((cyc - acc) >= 3 && req_valid) begin
                acc    <= cyc + 1;
                m_w    <= req_write;
                m_u    <= req_unsigned;
                m_sz   <= req_size;
                m_a    <= req_address;
                m_wd   <= req_wdata;
                e_addr <= req_address;
                e_ds   <= bus_code(req_size);
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            int k;
            k = cyc - acc;
            chk("req_ready", 32'(req_ready), 32'(k >= 3));
            chk("write_address", 32'(write_address), 32'(k == 0));
            chk("write", 32'(write), 32'(k == 1 && m_w));
            chk("read", 32'(read), 32'(k == 1 && !m_w));
            chk("resp_valid", 32'(resp_valid), 32'(k == 2));
            chk("resp_rdata", resp_rdata, (k == 2 && m_w) ? 32'd0 : hold);
            chk("address", 32'(address), 32'(e_addr));
            chk("data_size", 32'(data_size), 32'(e_ds));
            chk("strobe_excl", 32'(int'(write_address) + int'(write) + int'(read) <= 1), 32'd1);
            if (k == 1 && m_w)  chk("store_data", data, m_wd & size_mask(m_sz));
            if (k == 1 && !m_w) chk("load_bus_data", data, rd_word(m_a));
        end
    end

    // ---------------- Stimulus ----------------
    task automatic junk_fields();
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_address  = 16'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output logic [31:0] rd, output int lat);
        rd  = 32'd0;
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                rd  = resp_rdata;
                lat = i;
            end
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bit ok;
        wait_ready(ok);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_address = a; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        junk_fields();
        wait_resp(rd, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, t1, t2;
        bit ok;
        reset = 1'b1; req_valid = 1'b0;
        junk_fields();
        @(posedge clock);
        started = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_size", 32'(data_size), 32'd0);

        do_req(1'b1, 2'b00, 1'b0, 16'h0001, 32'h0000_00AA, rd, lat);
        chk("st_byte_rdata", rd, 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 16'h0001, 32'd0, rd, lat);
        chk("ld_sbyte", rd, 32'hFFFF_FFAA);
        chk("ld_sbyte_lat", 32'(lat), 32'd3);
        do_req(1'b0, 2'b00, 1'b1, 16'h0001, 32'd0, rd, lat);
        chk("ld_ubyte", rd, 32'h0000_00AA);

        do_req(1'b1, 2'b01, 1'b0, 16'h0002, 32'hFFFF_BBCC, rd, lat);
        do_req(1'b0, 2'b01, 1'b0, 16'h0002, 32'd0, rd, lat);
        chk("ld_shalf", rd, 32'hFFFF_BBCC);
        do_req(1'b0, 2'b01, 1'b1, 16'h0002, 32'd0, rd, lat);
        chk("ld_uhalf", rd, 32'h0000_BBCC);

        do_req(1'b1, 2'b10, 1'b0, 16'h0003, 32'hDDEE_FF00, rd, lat);
        do_req(1'b0, 2'b11, 1'b0, 16'h0003, 32'd0, rd, lat);
        chk("ld_word", rd, 32'hDDEE_FF00);
        chk("ld_word_lat", 32'(lat), 32'd3);

        do_req(1'b1, 2'b00, 1'b0, 16'h0004, 32'h0000_0011, rd, lat);
        do_req(1'b0, 2'b00, 1'b0, 16'h0004, 32'd0, rd, lat);
        chk("ld_sbyte_pos", rd, 32'h0000_0011);

        // Back-to-back with req_valid held high across both requests.
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_address = 16'h0100; req_wdata = 32'h1234_5678;
        @(posedge clock);
        #1 t1 = cyc;
        req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b1; req_address = 16'h0102;
        wait_ready(ok);
        @(posedge clock);
        #1 t2 = cyc;
        req_valid = 1'b0;
        chk("b2b_spacing", 32'(t2 - t1), 32'd4);
        wait_resp(rd, lat);
        chk("b2b_load", rd, 32'h0000_1234);
        chk("b2b_lat", 32'(lat), 32'd3);

        // Reset while a store is on the bus.
        do_req(1'b1, 2'b00, 1'b0, 16'h0020, 32'h0000_005A, rd, lat);
        wait_ready(ok);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_address = 16'h0020;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("xfer_write", 32'(write), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_strobes", 32'({write_address, write, read, resp_valid}), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 16'h0020, 32'd0, rd, lat);
        chk("post_rst_lat", 32'(lat), 32'd3);

        // Randomised traffic, including requests presented while busy.
        for (int i = 0; i < 800; i++) begin
            @(posedge clock);
            #1;
            reset     = ($urandom_range(0, 79) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            junk_fields();
            if ($urandom_range(0, 7) != 0) req_address = 16'($urandom_range(0, 47));
            else                           req_address = 16'($urandom_range(16'hFFFC, 16'hFFFF));
        end
        @(posedge clock);
        #1 reset = 1'b0; req_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
